// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_t;

    // Width of the shared counter type: large enough for the biggest limit.
    // One bit more than $clog2 so that a limit which is an exact power of two
    // still fits in the counter without wrapping.
    function automatic int cnt_width(input int rst_hold,
                                     input int lock_timeout,
                                     input int lock_stable,
                                     input int seq_gap2);
        int largest;
        largest = rst_hold;
        if (lock_timeout > largest) largest = lock_timeout;
        if (lock_stable > largest) largest = lock_stable;
        if (seq_gap2 > largest) largest = seq_gap2;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into refclk.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lock_async,
    output logic lock_sync
);

    logic meta;

    // Double-register the asynchronous lock input; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            meta      <= lock_async;
            lock_sync <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock supervisor and per-domain reset sequencer.
// Holds the PLL in reset, waits for a stable lock, releases the three domain
// resets in order, retries a bounded number of times and watches for lock loss.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int SEQ_GAP      = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                           refclk,
    input  logic                           rst,
    input  logic                           pll_locked,
    output logic                           pll_rst,
    output logic [2:0]                     domain_reset,
    output logic                           ready,
    output logic                           fail,
    output logic                           lock_lost,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int CW = cnt_width(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE, 2 * SEQ_GAP);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] HOLD_LIM  = CW'(RST_HOLD);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] GAP1      = CW'(SEQ_GAP);
    localparam logic [CW-1:0] GAP2      = CW'(2 * SEQ_GAP);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    logic          locked_sync;

    seq_state_t    state;
    seq_state_t    state_n;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_n;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_n;
    logic [CW-1:0] stb_cnt;
    logic [CW-1:0] stb_n;
    logic [CW-1:0] rel_cnt;
    logic [CW-1:0] rel_n;
    logic [CW-1:0] rel_inc;
    logic [RW-1:0] retry_n;
    logic          pll_rst_n;
    logic [2:0]    dr_n;
    logic          ready_n;
    logic          fail_n;
    logic          lost_n;

    pll_lock_sync u_lock_sync (
        .clk       (refclk),
        .rst       (rst),
        .lock_async(pll_locked),
        .lock_sync (locked_sync)
    );

    // State, counters and all outputs are registered together.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            tmo_cnt      <= '0;
            stb_cnt      <= '0;
            rel_cnt      <= '0;
            retry_cnt    <= '0;
            pll_rst      <= 1'b1;
            domain_reset <= '1;
            ready        <= 1'b0;
            fail         <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            tmo_cnt      <= tmo_n;
            stb_cnt      <= stb_n;
            rel_cnt      <= rel_n;
            retry_cnt    <= retry_n;
            pll_rst      <= pll_rst_n;
            domain_reset <= dr_n;
            ready        <= ready_n;
            fail         <= fail_n;
            lock_lost    <= lost_n;
        end
    end

    // Next-state, counter and output decode for the sequencer.
    // hold_cnt counts pll_rst-high cycles: after rst nothing has been counted
    // yet, whereas a retry or lock-loss entry edge already drives pll_rst high,
    // so those entries preload 1 to give RST_HOLD high cycles in every case.
    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        tmo_n     = tmo_cnt;
        stb_n     = stb_cnt;
        rel_n     = rel_cnt;
        rel_inc   = rel_cnt + 1'b1;
        retry_n   = retry_cnt;
        pll_rst_n = pll_rst;
        dr_n      = domain_reset;
        ready_n   = 1'b0;
        fail_n    = 1'b0;
        lost_n    = 1'b0;

        case (state)
            HOLD: begin
                pll_rst_n = 1'b1;
                dr_n      = '1;
                if (hold_cnt >= HOLD_LIM) begin
                    state_n   = WAIT;
                    pll_rst_n = 1'b0;
                    hold_n    = '0;
                    tmo_n     = '0;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end

            WAIT, STABLE: begin
                pll_rst_n = 1'b0;
                dr_n      = '1;
                // Timeout is checked first so it beats both a lock rise and a
                // stable count completing on the same edge.
                if (tmo_cnt >= TMO_LAST) begin
                    pll_rst_n = 1'b1;
                    if (retry_cnt < RETRY_LIM) begin
                        retry_n = retry_cnt + 1'b1;
                        state_n = HOLD;
                        hold_n  = CW'(1);
                    end else begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                    end
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                    if (state == WAIT) begin
                        if (locked_sync) begin
                            state_n = STABLE;
                            stb_n   = '0;
                        end
                    end else if (!locked_sync) begin
                        state_n = WAIT;
                    end else if (stb_cnt >= STB_LAST) begin
                        state_n = RELEASE;
                        rel_n   = '0;
                        dr_n    = 3'b110;
                    end else begin
                        stb_n = stb_cnt + 1'b1;
                    end
                end
            end

            RELEASE, RUN: begin
                pll_rst_n = 1'b0;
                if (!locked_sync) begin
                    state_n   = HOLD;
                    hold_n    = CW'(1);
                    pll_rst_n = 1'b1;
                    dr_n      = '1;
                    lost_n    = 1'b1;
                    retry_n   = '0;
                end else if (state == RUN) begin
                    ready_n = 1'b1;
                    dr_n    = '0;
                end else if (rel_cnt >= GAP2) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                    dr_n    = '0;
                end else begin
                    rel_n = rel_inc;
                    if (rel_inc >= GAP1) dr_n[1] = 1'b0;
                    if (rel_inc >= GAP2) dr_n[2] = 1'b0;
                end
            end

            FAIL: begin
                pll_rst_n = 1'b1;
                dr_n      = '1;
                fail_n    = 1'b1;
            end

            default: begin
                state_n   = HOLD;
                pll_rst_n = 1'b1;
                dr_n      = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: a trace-level reference model predicts
// every cycle's outputs from the pll_locked waveform; a monitor compares them.
module tb_pll_reset_seq;

    localparam int RH   = 4;
    localparam int LT   = 100;
    localparam int LS   = 8;
    localparam int G    = 3;
    localparam int MR   = 2;
    localparam int MAXN = 600;

    typedef struct packed {
        logic       pll_rst;
        logic [2:0] dr;
        logic       ready;
        logic       fail;
        logic       lost;
        logic [1:0] retry;
    } out_t;

    typedef struct {
        int   scen;
        int   cyc;
        out_t v;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] domain_reset;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    item_t sb[$];

    bit    lk[MAXN];
    out_t  ex[MAXN];
    int    n_cyc;
    int    rst_at;

    pll_reset_seq #(
        .RST_HOLD    (RH),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .SEQ_GAP     (G),
        .MAX_RETRY   (MR)
    ) dut (
        .refclk      (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .domain_reset(domain_reset),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(bit pr, logic [2:0] dr, bit rdy, bit fl, bit lost, int rc);
        out_t o;
        o.pll_rst = pr;
        o.dr      = dr;
        o.ready   = rdy;
        o.fail    = fl;
        o.lost    = lost;
        o.retry   = rc[1:0];
        return o;
    endfunction

    // Lock as seen by the sequencer at edge e: two cycles late, zero for the
    // first two edges after a reset edge.
    function automatic bit samp(int e, int last_rst);
        int k;
        k = e - 2;
        if (k < 0 || k <= last_rst) return 1'b0;
        return lk[k];
    endfunction

    task automatic put(int c, out_t v);
        if (c >= 0 && c < n_cyc) ex[c] = v;
    endtask

    // Bring-up attempts as windows: hold, then search for LS+1 consecutive
    // locked samples before the deadline, then the release staircase until
    // the first unlocked sample.
    task automatic model_from(int b, int last_rst);
        int h, w, t, r, run, l, rc;
        bit lost_pending;
        logic [2:0] dr;
        h = b;
        rc = 0;
        lost_pending = 1'b0;
        while (h < n_cyc) begin
            for (int c = h; c < h + RH; c++) put(c, mk(1, 3'b111, 0, 0, 0, rc));
            if (lost_pending) ex[h].lost = 1'b1;
            lost_pending = 1'b0;
            w = h + RH;
            r = -1;
            run = 0;
            for (int e = w + 1; e < w + LT && e < n_cyc; e++) begin
                if (samp(e, last_rst)) run++;
                else run = 0;
                if (run == LS + 1) begin
                    r = e;
                    break;
                end
            end
            if (r < 0) begin
                t = w + LT;
                for (int c = w; c < t; c++) put(c, mk(0, 3'b111, 0, 0, 0, rc));
                if (rc < MR) begin
                    rc++;
                    h = t;
                end else begin
                    for (int c = t; c < n_cyc; c++) put(c, mk(1, 3'b111, 0, 1, 0, rc));
                    h = n_cyc;
                end
            end else begin
                for (int c = w; c < r; c++) put(c, mk(0, 3'b111, 0, 0, 0, rc));
                l = r + 1;
                while (l < n_cyc && samp(l, last_rst)) l++;
                for (int c = r; c < l; c++) begin
                    if (c < r + G) dr = 3'b110;
                    else if (c < r + 2 * G) dr = 3'b100;
                    else dr = 3'b000;
                    put(c, mk(0, dr, c >= r + 2 * G + 1, 0, 0, rc));
                end
                rc = 0;
                lost_pending = 1'b1;
                h = l;
            end
        end
    endtask

    task automatic build();
        model_from(0, -1);
        if (rst_at >= 0) begin
            ex[rst_at] = mk(1, 3'b111, 0, 0, 0, 0);
            model_from(rst_at + 1, rst_at);
        end
    endtask

    task automatic clear_lk();
        for (int c = 0; c < MAXN; c++) lk[c] = 1'b0;
        rst_at = -1;
    endtask

    task automatic rise_at(int r);
        for (int c = r; c < MAXN; c++) lk[c] = 1'b1;
    endtask

    task automatic drive(bit r, bit l, out_t v, int scen, int cyc);
        item_t it;
        @(negedge clk);
        rst        = r;
        pll_locked = l;
        it.scen = scen;
        it.cyc  = cyc;
        it.v    = v;
        sb.push_back(it);
    endtask

    task automatic run_scen(int id);
        build();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, mk(1, 3'b111, 0, 0, 0, 0), id, -1);
        for (int c = 0; c < n_cyc; c++) drive(c == rst_at, lk[c], ex[c], id, c);
    endtask

    task automatic gen_random();
        int r, gl;
        clear_lk();
        n_cyc = $urandom_range(150, 450);
        r = $urandom_range(0, 260);
        gl = 0;
        for (int c = 0; c < n_cyc; c++) begin
            if (c < r) lk[c] = 1'b0;
            else if (gl > 0) begin
                lk[c] = 1'b0;
                gl--;
            end else if ($urandom_range(0, 59) == 0) begin
                lk[c] = 1'b0;
                gl = $urandom_range(0, 2);
            end else lk[c] = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) rst_at = $urandom_range(5, n_cyc - 10);
    endtask

    task automatic chk(string nm, int scen, int cyc, logic [7:0] got, logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s scen=%0d cycle=%0d got=%0h expected=%0h", nm, scen, cyc, got, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction after every edge.
    always @(posedge clk) begin
        item_t it;
        #1;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk("pll_rst",      it.scen, it.cyc, {7'b0, pll_rst},      {7'b0, it.v.pll_rst});
            chk("domain_reset", it.scen, it.cyc, {5'b0, domain_reset}, {5'b0, it.v.dr});
            chk("ready",        it.scen, it.cyc, {7'b0, ready},        {7'b0, it.v.ready});
            chk("fail",         it.scen, it.cyc, {7'b0, fail},         {7'b0, it.v.fail});
            chk("lock_lost",    it.scen, it.cyc, {7'b0, lock_lost},    {7'b0, it.v.lost});
            chk("retry_cnt",    it.scen, it.cyc, {6'b0, retry_cnt},    {6'b0, it.v.retry});
        end
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;

        clear_lk(); n_cyc = 60;  rise_at(10);                 run_scen(0);
        clear_lk(); n_cyc = 340;                              run_scen(1);
        clear_lk(); n_cyc = 60;  rise_at(10); lk[15] = 1'b0;  run_scen(2);
        clear_lk(); n_cyc = 120; rise_at(10);
        for (int c = 40; c < 50; c++) lk[c] = 1'b0;
        run_scen(3);
        clear_lk(); n_cyc = 160; rise_at(102);                run_scen(4);
        clear_lk(); n_cyc = 80;  rise_at(10); rst_at = 24;    run_scen(5);

        for (int s = 6; s < 14; s++) begin
            gen_random();
            run_scen(s);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
